if_prefetch_stage: RTL and testbench



---
 rtl/if_prefetch_stage.sv | 163 ++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: sequential request/grant fetching into a DEPTH-entry prefetch FIFO.
// Redirects flush the FIFO and discard responses for requests issued before the redirect.
module if_prefetch_stage #(
  parameter int                XLEN     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter logic [XLEN-1:0]   NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic            jump2exp,
  input  logic [XLEN-1:0] meh_addr,
  input  logic            ex_is_mret_inst,
  input  logic [XLEN-1:0] mret_addr,
  input  logic            bj_flag,
  input  logic [XLEN-1:0] bj_addr,
  input  logic            pipe_stall,
  output logic            ibus_req,
  output logic [XLEN-1:0] ibus_addr,
  input  logic            ibus_gnt,
  input  logic            ibus_rvalid,
  input  logic [XLEN-1:0] ibus_rdata,
  output logic            if_out_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_exp_flag,
  output logic            if_inst_addr_misal
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_MISAL, S_HALT} state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [CW-1:0]     r_out, r_disc, r_cnt, w_out_nxt;
  logic [AW-1:0]     r_rd, r_wr, r_pcq_rd, r_pcq_wr;

  logic [XLEN-1:0]   r_f_pc   [DEPTH];
  logic [XLEN-1:0]   r_f_inst [DEPTH];
  logic              r_f_exp  [DEPTH];
  logic              r_f_mis  [DEPTH];
  logic [XLEN-1:0]   r_pcq    [DEPTH];

  logic              w_redirect, w_misal_tgt, w_fire, w_push, w_pop;
  logic [XLEN-1:0]   w_target;
  logic              w_wr_en, w_wr_exp;
  logic [AW-1:0]     w_wr_idx;
  logic [XLEN-1:0]   w_wr_pc, w_wr_inst;

  assign w_redirect  = jump2exp | ex_is_mret_inst | bj_flag;
  assign w_target    = jump2exp ? meh_addr : (ex_is_mret_inst ? mret_addr : bj_addr);
  assign w_misal_tgt = |w_target[1:0];

  // Outstanding count includes requests whose responses will be discarded.
  assign ibus_req  = rst_n & (r_state == S_FETCH) & if_valid & ~w_redirect &
                     (({1'b0, r_out} + {1'b0, r_cnt}) < CAP);
  assign ibus_addr = r_fetch_pc;
  assign w_fire    = ibus_req & ibus_gnt;
  assign w_push    = ibus_rvalid & ~w_redirect & (r_disc == '0);
  assign w_pop     = if_out_valid & ~pipe_stall & ~w_redirect;
  assign w_out_nxt = r_out + CW'(w_fire) - CW'(ibus_rvalid);

  always_comb begin
    w_state_nxt = r_state;
    if (w_redirect) begin
      w_state_nxt = w_misal_tgt ? S_MISAL : S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: if (!if_valid) w_state_nxt = S_HALT;
        S_HALT:  if (if_valid)  w_state_nxt = S_FETCH;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Fetch PC, outstanding and discard counters, PC queue pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_disc     <= '0;
      r_pcq_rd   <= '0;
      r_pcq_wr   <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_disc     <= w_out_nxt;
        r_pcq_rd   <= '0;
        r_pcq_wr   <= '0;
      end else begin
        if (w_fire) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
          r_pcq_wr   <= r_pcq_wr + AW'(1);
        end
        if (ibus_rvalid && r_disc != '0) r_disc <= r_disc - CW'(1);
        if (w_push) r_pcq_rd <= r_pcq_rd + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) r_pcq[r_pcq_wr] <= r_fetch_pc;
  end

  // A misaligned redirect writes its exception entry into slot 0 of the flushed FIFO.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = r_wr;
    w_wr_pc   = r_pcq[r_pcq_rd];
    w_wr_inst = ibus_rdata;
    w_wr_exp  = 1'b0;
    if (w_redirect) begin
      w_wr_en   = w_misal_tgt;
      w_wr_idx  = '0;
      w_wr_pc   = w_target;
      w_wr_inst = NOP_INST;
      w_wr_exp  = 1'b1;
    end else if (w_push) begin
      w_wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_f_pc[w_wr_idx]   <= w_wr_pc;
      r_f_inst[w_wr_idx] <= w_wr_inst;
      r_f_exp[w_wr_idx]  <= w_wr_exp;
      r_f_mis[w_wr_idx]  <= w_wr_exp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (w_redirect) begin
      r_rd  <= '0;
      r_wr  <= w_misal_tgt ? AW'(1) : '0;
      r_cnt <= w_misal_tgt ? CW'(1) : '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  assign if_out_valid       = (r_cnt != '0);
  assign if_pc              = if_out_valid ? r_f_pc[r_rd]   : '0;
  assign if_inst            = if_out_valid ? r_f_inst[r_rd] : '0;
  assign if_exp_flag        = if_out_valid & r_f_exp[r_rd];
  assign if_inst_addr_misal = if_out_valid & r_f_mis[r_rd];

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: a per-cycle vector table for streaming and
// back-pressure, then hand sequences for redirect, priority, misalignment, wrap and halt.
module tb_if_prefetch_stage;
  logic        clk = 1'b0, rst_n = 1'b0, if_valid = 1'b0;
  logic        jump2exp = 1'b0, ex_is_mret_inst = 1'b0, bj_flag = 1'b0, pipe_stall = 1'b0;
  logic [31:0] meh_addr = '0, mret_addr = '0, bj_addr = '0;
  logic        ibus_gnt = 1'b0, ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = '0;
  logic        ibus_req, if_out_valid, if_exp_flag, if_inst_addr_misal;
  logic [31:0] ibus_addr, if_pc, if_inst;

  if_prefetch_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP_INST(32'h13)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid),
    .jump2exp(jump2exp), .meh_addr(meh_addr),
    .ex_is_mret_inst(ex_is_mret_inst), .mret_addr(mret_addr),
    .bj_flag(bj_flag), .bj_addr(bj_addr), .pipe_stall(pipe_stall),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
    .if_out_valid(if_out_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_exp_flag(if_exp_flag), .if_inst_addr_misal(if_inst_addr_misal)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, resp_lat = 1;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  // In-order bus responder: a grant sampled at an edge answers resp_lat cycles later.
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t rq[$];
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) rq.delete();
    else if (ibus_req && ibus_gnt) rq.push_back('{ibus_addr, cyc + resp_lat - 1});
    #1;
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      ibus_rvalid = 1'b1;
      ibus_rdata  = rq[0].addr ^ KEY;
      void'(rq.pop_front());
    end else begin
      ibus_rvalid = 1'b0;
      ibus_rdata  = '0;
    end
  end

  typedef struct { logic stall; logic req; logic vld; logic [31:0] pc; } vec_t;
  vec_t tv[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pipe_stall = 1'b0; if_valid = 1'b1; ibus_gnt = 1'b1;
    jump2exp = 1'b0; ex_is_mret_inst = 1'b0; bj_flag = 1'b0;
    next(); next();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    tv = '{
      '{1'b0, 1'b1, 1'b0, 32'h00}, '{1'b0, 1'b1, 1'b0, 32'h00}, '{1'b0, 1'b1, 1'b1, 32'h00},
      '{1'b0, 1'b1, 1'b1, 32'h04}, '{1'b0, 1'b1, 1'b1, 32'h08}, '{1'b0, 1'b1, 1'b1, 32'h0C},
      '{1'b0, 1'b1, 1'b1, 32'h10},
      '{1'b1, 1'b1, 1'b1, 32'h14}, '{1'b1, 1'b1, 1'b1, 32'h14}, '{1'b1, 1'b0, 1'b1, 32'h14},
      '{1'b1, 1'b0, 1'b1, 32'h14}, '{1'b1, 1'b0, 1'b1, 32'h14}, '{1'b1, 1'b0, 1'b1, 32'h14},
      '{1'b1, 1'b0, 1'b1, 32'h14}, '{1'b1, 1'b0, 1'b1, 32'h14}, '{1'b1, 1'b0, 1'b1, 32'h14},
      '{1'b1, 1'b0, 1'b1, 32'h14},
      '{1'b0, 1'b0, 1'b1, 32'h14}, '{1'b0, 1'b1, 1'b1, 32'h18}, '{1'b0, 1'b1, 1'b1, 32'h1C},
      '{1'b0, 1'b1, 1'b1, 32'h20}, '{1'b0, 1'b1, 1'b1, 32'h24}, '{1'b0, 1'b1, 1'b1, 32'h28}
    };

    // Reset state while rst_n is held low.
    rst_n = 1'b0; if_valid = 1'b1; ibus_gnt = 1'b1;
    next(); next(); #1;
    chk("rst_req",   32'(ibus_req), 32'h0);
    chk("rst_addr",  ibus_addr, 32'h0);
    chk("rst_valid", 32'(if_out_valid), 32'h0);
    chk("rst_pc",    if_pc, 32'h0);
    chk("rst_inst",  if_inst, 32'h0);
    chk("rst_exp",   32'(if_exp_flag), 32'h0);
    chk("rst_misal", 32'(if_inst_addr_misal), 32'h0);
    @(negedge clk);
    next();
    rst_n = 1'b1;

    // Streaming then 10 stalled cycles then release.
    for (int i = 0; i < 23; i++) begin
      pipe_stall = tv[i].stall; #1;
      chk($sformatf("vec%0d_req", i),   32'(ibus_req), 32'(tv[i].req));
      chk($sformatf("vec%0d_valid", i), 32'(if_out_valid), 32'(tv[i].vld));
      chk($sformatf("vec%0d_pc", i),    if_pc, tv[i].vld ? tv[i].pc : 32'h0);
      chk($sformatf("vec%0d_inst", i),  if_inst, tv[i].vld ? (tv[i].pc ^ KEY) : 32'h0);
      next();
    end

    // Redirect with three requests in flight; old responses must never reach the FIFO.
    resp_lat = 4;
    do_reset();
    next(); next(); next();
    bj_addr = 32'h100; bj_flag = 1'b1; #1;
    chk("redir_req_low", 32'(ibus_req), 32'h0);
    next(); bj_flag = 1'b0; #1;
    chk("redir_req", 32'(ibus_req), 32'h1);
    chk("redir_addr", ibus_addr, 32'h100);
    chk("redir_valid_low", 32'(if_out_valid), 32'h0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (if_out_valid) begin
        found = 1'b1;
        chk("redir_first_pc", if_pc, 32'h100);
        chk("redir_first_inst", if_inst, 32'h100 ^ KEY);
      end else next();
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL redir_timeout: got no output expected pc 00000100");
    end

    // Priority: exception beats mret beats branch; the queue is flushed.
    resp_lat = 1;
    do_reset();
    next(); next(); next(); next(); next(); #1;
    chk("prio_pre_valid", 32'(if_out_valid), 32'h1);
    meh_addr = 32'h80; mret_addr = 32'h200; bj_addr = 32'h300;
    jump2exp = 1'b1; ex_is_mret_inst = 1'b1; bj_flag = 1'b1; #1;
    chk("prio_req_low", 32'(ibus_req), 32'h0);
    next(); jump2exp = 1'b0; ex_is_mret_inst = 1'b0; bj_flag = 1'b0; #1;
    chk("prio_addr", ibus_addr, 32'h80);
    chk("prio_req", 32'(ibus_req), 32'h1);
    chk("prio_flush", 32'(if_out_valid), 32'h0);
    next();
    chk("prio_gap", 32'(if_out_valid), 32'h0);
    next();
    chk("prio_out_pc", if_pc, 32'h80);

    // Misaligned branch target: single exception entry, fetching stops.
    bj_addr = 32'h102; bj_flag = 1'b1;
    next(); bj_flag = 1'b0; #1;
    chk("mis_valid", 32'(if_out_valid), 32'h1);
    chk("mis_pc", if_pc, 32'h102);
    chk("mis_inst", if_inst, 32'h13);
    chk("mis_exp", 32'(if_exp_flag), 32'h1);
    chk("mis_flag", 32'(if_inst_addr_misal), 32'h1);
    chk("mis_req", 32'(ibus_req), 32'h0);
    next(); #1;
    chk("mis_single", 32'(if_out_valid), 32'h0);
    chk("mis_req2", 32'(ibus_req), 32'h0);
    next();
    meh_addr = 32'h80; jump2exp = 1'b1;
    next(); jump2exp = 1'b0; #1;
    chk("mis_resume_req", 32'(ibus_req), 32'h1);
    chk("mis_resume_addr", ibus_addr, 32'h80);

    // Wrap past the top of the address space, then halt with a response pending.
    next();
    bj_addr = 32'hFFFF_FFFC; bj_flag = 1'b1;
    next(); bj_flag = 1'b0; #1;
    chk("wrap_top", ibus_addr, 32'hFFFF_FFFC);
    next(); #1;
    chk("wrap_zero", ibus_addr, 32'h0);
    chk("wrap_req", 32'(ibus_req), 32'h1);
    next();
    if_valid = 1'b0; #1;
    chk("halt_req", 32'(ibus_req), 32'h0);
    chk("halt_head", if_pc, 32'hFFFF_FFFC);
    next();
    chk("halt_req_next", 32'(ibus_req), 32'h0);
    chk("halt_pending_pc", if_pc, 32'h0);
    chk("halt_pending_inst", if_inst, KEY);
    next();
    chk("halt_drained", 32'(if_out_valid), 32'h0);
    if_valid = 1'b1;
    next(); #1;
    chk("halt_resume_req", 32'(ibus_req), 32'h1);
    chk("halt_resume_addr", ibus_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
